combo_lock_ctrl: RTL
====================

// Module: combo_lock_ctrl
// PURPOSE
//  Sequencer for the switch/button combination lock: walks NUM_STEPS 16-bit code entries,
//  holds the code in reprogrammable registers, counts failed attempts, enforces a lockout.
//  Sits between the button one-shots (start/enter pulses) and the LED/status display logic.
// PARAMETERS
//  NUM_STEPS      3                               code entries per attempt (>=2)
//  MAX_FAILS      3                               consecutive failed attempts before lockout (>=1)
//  LOCKOUT_CYCLES 100_000_000                     clk cycles spent in LOCKOUT (>=1)
//  DEFAULT_CODE   {16'h4AA7,16'hF3CF,16'h0001}    reset code, step k = bits [16k+15:16k]
// PORTS
//  clk        in   1                    system clock, all state on posedge
//  reset      in   1                    asynchronous, active-high
//  start      in   1                    one-cycle pulse (centre-button one-shot)
//  enter      in   1                    one-cycle pulse (any other button one-shot)
//  prog       in   1                    level; request reprogramming while UNLOCKED
//  sw         in   16                   switch value sampled on enter
//  state      out  3                    IDLE=0 ENTER=1 UNLOCKED=2 PROGRAM=3 LOCKOUT=4
//  step_idx   out  $clog2(NUM_STEPS)    current entry index in ENTER/PROGRAM, else 0
//  fail_cnt   out  $clog2(MAX_FAILS+1)  consecutive failed attempts
//  unlocked   out  1                    high iff state==UNLOCKED
//  locked_out out  1                    high iff state==LOCKOUT
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, step_idx=0, fail_cnt=0, timer=0, unlocked=0,
//   locked_out=0, code regs and shadow regs = DEFAULT_CODE. Reset mid-entry/program/lockout
//   aborts immediately and restores DEFAULT_CODE.
//  All outputs registered or decoded from registered state; pulse effects visible next cycle.
//  IDLE: start -> ENTER, step_idx=0. enter ignored.
//  ENTER, on enter (enter has priority over start; start alone ignored in ENTER):
//   - sw==code[step_idx], step_idx<NUM_STEPS-1 -> step_idx+1.
//   - sw==code[step_idx], last step -> UNLOCKED, fail_cnt=0, step_idx=0.
//   - mismatch -> step_idx=0; if fail_cnt+1==MAX_FAILS -> LOCKOUT, fail_cnt=MAX_FAILS,
//     timer=LOCKOUT_CYCLES-1; else fail_cnt+1, -> IDLE. Mismatch rejects on the failing step.
//  UNLOCKED: start -> IDLE (start wins if start and prog together); else prog high -> PROGRAM,
//   step_idx=0. enter ignored.
//  PROGRAM, on enter: shadow[step_idx]=sw; non-last step -> step_idx+1; last step -> all code
//   regs = shadow (including this sw) in same edge, -> UNLOCKED, step_idx=0.
//   start (without enter) -> abort to UNLOCKED, code regs unchanged, shadow reloaded from code.
//   enter+start same cycle: enter processed, start ignored. prog level ignored once in PROGRAM.
//  LOCKOUT: all inputs ignored; timer decrements each cycle; when timer==0 -> IDLE, fail_cnt=0.
//   Duration in LOCKOUT exactly LOCKOUT_CYCLES cycles.
//  fail_cnt saturates at MAX_FAILS; never wraps. step_idx never exceeds NUM_STEPS-1.
//  Unused state encodings (5-7) -> IDLE next cycle, step_idx=0.
// TESTING (bench uses LOCKOUT_CYCLES=10, other defaults)
//  1 start; enter sw=0001, F3CF, 4AA7 -> state 1,1,1,2; step_idx 1,2,0; unlocked=1; fail_cnt=0.
//  2 start; enter sw=0001, then sw=1234 -> state=IDLE, step_idx=0, fail_cnt=1.
//  3 three failed attempts -> third fail enters LOCKOUT, locked_out=1 for exactly 10 cycles;
//    start/enter pulses during lockout ignored; then IDLE, fail_cnt=0.
//  4 unlock, prog=1; enter AAAA, BBBB, CCCC -> UNLOCKED; start -> IDLE; old code 0001 rejected;
//    AAAA,BBBB,CCCC accepted.
//  5 PROGRAM, enter AAAA, then start -> UNLOCKED, default code still unlocks; enter+start in ENTER
//    same cycle -> enter processed.
//  6 assert reset asynchronously mid-ENTER (step_idx=2) and mid-LOCKOUT -> outputs zero before
//    next clk edge; after reprogramming then reset, DEFAULT_CODE unlocks.

Source files
------------

// File: rtl/combo_lock_ctrl_if.sv
// rtl/combo_lock_ctrl_if.sv - button/switch inputs and status outputs of the combination lock
interface combo_lock_ctrl_if #(
    parameter int NUM_STEPS = 3,
    parameter int MAX_FAILS = 3
);
    localparam int SW = $clog2(NUM_STEPS);
    localparam int FW = $clog2(MAX_FAILS + 1);

    logic          start;
    logic          enter;
    logic          prog;
    logic [15:0]   sw;
    logic [2:0]    state;
    logic [SW-1:0] step_idx;
    logic [FW-1:0] fail_cnt;
    logic          unlocked;
    logic          locked_out;

    modport master (
        output start, enter, prog, sw,
        input  state, step_idx, fail_cnt, unlocked, locked_out
    );

    modport slave (
        input  start, enter, prog, sw,
        output state, step_idx, fail_cnt, unlocked, locked_out
    );
endinterface

// File: rtl/combo_lock_ctrl.sv
// rtl/combo_lock_ctrl.sv - combination lock sequencer with reprogrammable code and lockout
module combo_lock_ctrl #(
    parameter int                      NUM_STEPS      = 3,
    parameter int                      MAX_FAILS      = 3,
    parameter int                      LOCKOUT_CYCLES = 100_000_000,
    parameter logic [16*NUM_STEPS-1:0] DEFAULT_CODE   = {16'h4AA7, 16'hF3CF, 16'h0001}
) (
    input logic               clk,
    input logic               reset,
    combo_lock_ctrl_if.slave  bus
);
    localparam int SW = $clog2(NUM_STEPS);
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int TW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    localparam logic [SW-1:0] LAST_STEP  = SW'(NUM_STEPS - 1);
    localparam logic [FW-1:0] FAIL_LIMIT = FW'(MAX_FAILS);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(LOCKOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ENTER    = 3'd1,
        S_UNLOCKED = 3'd2,
        S_PROGRAM  = 3'd3,
        S_LOCKOUT  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] step_q, step_d;
    logic [FW-1:0] fail_q, fail_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [15:0]   code_q   [NUM_STEPS];
    logic [15:0]   shadow_q [NUM_STEPS];
    logic          shadow_wr;
    logic          code_commit;
    logic          shadow_reload;
    logic          code_match;

    assign code_match = (bus.sw == code_q[step_q]);

    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        fail_d        = fail_q;
        timer_d       = timer_q;
        shadow_wr     = 1'b0;
        code_commit   = 1'b0;
        shadow_reload = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_ENTER;
                    step_d  = '0;
                end
            end
            S_ENTER: begin
                if (bus.enter) begin
                    if (code_match) begin
                        if (step_q == LAST_STEP) begin
                            state_d = S_UNLOCKED;
                            fail_d  = '0;
                            step_d  = '0;
                        end else begin
                            step_d = step_q + 1'b1;
                        end
                    end else begin
                        // a wrong entry rejects the attempt right away, not after the last step
                        step_d = '0;
                        if (fail_q >= FAIL_LIMIT - 1'b1) begin
                            state_d = S_LOCKOUT;
                            fail_d  = FAIL_LIMIT;
                            timer_d = TIMER_LOAD;
                        end else begin
                            fail_d  = fail_q + 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            S_UNLOCKED: begin
                if (bus.start) begin
                    state_d = S_IDLE;
                    step_d  = '0;
                end else if (bus.prog) begin
                    state_d = S_PROGRAM;
                    step_d  = '0;
                end
            end
            S_PROGRAM: begin
                if (bus.enter) begin
                    shadow_wr = 1'b1;
                    if (step_q == LAST_STEP) begin
                        code_commit = 1'b1;
                        state_d     = S_UNLOCKED;
                        step_d      = '0;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end else if (bus.start) begin
                    shadow_reload = 1'b1;
                    state_d       = S_UNLOCKED;
                    step_d        = '0;
                end
            end
            S_LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d = S_IDLE;
                    fail_d  = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                step_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            fail_q  <= '0;
            timer_q <= '0;
            for (int k = 0; k < NUM_STEPS; k++) begin
                code_q[k]   <= DEFAULT_CODE[16*k +: 16];
                shadow_q[k] <= DEFAULT_CODE[16*k +: 16];
            end
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            fail_q  <= fail_d;
            timer_q <= timer_d;
            for (int k = 0; k < NUM_STEPS; k++) begin
                if (shadow_reload) begin
                    shadow_q[k] <= code_q[k];
                end else if (shadow_wr && (SW'(k) == step_q)) begin
                    shadow_q[k] <= bus.sw;
                end
                // the final entry is still in flight, so it bypasses the shadow on commit
                if (code_commit) begin
                    code_q[k] <= (SW'(k) == step_q) ? bus.sw : shadow_q[k];
                end
            end
        end
    end

    assign bus.state      = state_q;
    assign bus.step_idx   = step_q;
    assign bus.fail_cnt   = fail_q;
    assign bus.unlocked   = (state_q == S_UNLOCKED);
    assign bus.locked_out = (state_q == S_LOCKOUT);
endmodule
